// File: rtl/gin_pkg.sv
// Shared defaults and helpers for the global input network.
package gin_pkg;

    localparam int unsigned GIN_NUMS_PE_ROW = 6;
    localparam int unsigned GIN_NUMS_PE_COL = 8;
    localparam int unsigned GIN_DATA_BITS   = 32;
    localparam int unsigned GIN_XID_BITS    = 5;
    localparam int unsigned GIN_YID_BITS    = 5;

    function automatic int unsigned pe_index(input int unsigned row, input int unsigned col,
                                             input int unsigned ncol);
        return row * ncol + col;
    endfunction

endpackage

// File: rtl/gin_id_scan_chain.sv
// Shift-register chain holding programmable PE IDs; entry 0 takes the scan input.
module gin_id_scan_chain #(
    parameter int unsigned DEPTH   = 6,
    parameter int unsigned ID_SIZE = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set_id,
    input  logic [ID_SIZE-1:0]         ID_scan_in,
    output logic [ID_SIZE-1:0]         ID_scan_out,
    output logic [DEPTH*ID_SIZE-1:0]   ID_out
);

    logic [DEPTH*ID_SIZE-1:0] chain_q, chain_d;

    always_comb begin
        chain_d = chain_q;
        if (set_id) begin
            chain_d[ID_SIZE-1:0] = ID_scan_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                chain_d[k*ID_SIZE +: ID_SIZE] = chain_q[(k-1)*ID_SIZE +: ID_SIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign ID_out      = chain_q;
    assign ID_scan_out = chain_q[(DEPTH-1)*ID_SIZE +: ID_SIZE];

endmodule

// File: rtl/gin.sv
// Global input network: buffers one GLB word and multicasts it to every PE whose
// (row ID, column ID) matches the word's tags, tracking delivery per PE.
module gin
    import gin_pkg::*;
#(
    parameter int unsigned NUMS_PE_ROW = GIN_NUMS_PE_ROW,
    parameter int unsigned NUMS_PE_COL = GIN_NUMS_PE_COL,
    parameter int unsigned DATA_BITS   = GIN_DATA_BITS,
    parameter int unsigned XID_BITS    = GIN_XID_BITS,
    parameter int unsigned YID_BITS    = GIN_YID_BITS
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       GIN_valid,
    output logic                                       GIN_ready,
    input  logic [DATA_BITS-1:0]                       GIN_data,
    input  logic [XID_BITS-1:0]                        tag_X,
    input  logic [YID_BITS-1:0]                        tag_Y,
    input  logic                                       set_XID,
    input  logic [XID_BITS-1:0]                        XID_scan_in,
    input  logic                                       set_YID,
    input  logic [YID_BITS-1:0]                        YID_scan_in,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         PE_valid,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         PE_ready,
    output logic [DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_data
);

    localparam int unsigned NUM_PE = NUMS_PE_ROW * NUMS_PE_COL;

    logic [NUMS_PE_ROW*YID_BITS-1:0] yid;
    logic [NUM_PE*XID_BITS-1:0]      xid;
    logic [NUM_PE-1:0]               target;
    logic [NUM_PE-1:0]               pending_q, pending_d;
    logic [DATA_BITS-1:0]            data_q, data_d;
    logic                            accept;

    gin_id_scan_chain #(
        .DEPTH   (NUMS_PE_ROW),
        .ID_SIZE (YID_BITS)
    ) u_yid_chain (
        .clk         (clk),
        .rst         (rst),
        .set_id      (set_YID),
        .ID_scan_in  (YID_scan_in),
        .ID_scan_out (),
        .ID_out      (yid)
    );

    gin_id_scan_chain #(
        .DEPTH   (NUM_PE),
        .ID_SIZE (XID_BITS)
    ) u_xid_chain (
        .clk         (clk),
        .rst         (rst),
        .set_id      (set_XID),
        .ID_scan_in  (XID_scan_in),
        .ID_scan_out (),
        .ID_out      (xid)
    );

    always_comb begin
        target = '0;
        for (int unsigned r = 0; r < NUMS_PE_ROW; r++) begin
            for (int unsigned c = 0; c < NUMS_PE_COL; c++) begin
                target[pe_index(r, c, NUMS_PE_COL)] =
                    (yid[r*YID_BITS +: YID_BITS] == tag_Y) &&
                    (xid[pe_index(r, c, NUMS_PE_COL)*XID_BITS +: XID_BITS] == tag_X);
            end
        end
    end

    // Ready as soon as every outstanding PE completes this cycle, so a new word can
    // overwrite the mask with no bubble.
    assign GIN_ready = ((pending_q & ~PE_ready) == '0);
    assign accept    = GIN_valid && GIN_ready;

    always_comb begin
        pending_d = pending_q & ~PE_ready;
        data_d    = data_q;
        if (accept) begin
            pending_d = target;
            data_d    = GIN_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    assign PE_valid = pending_q;
    assign PE_data  = {NUM_PE{data_q}};

endmodule

// File: doc/gin.md
Name: gin

Overview:
- Global Input Network: the GLB→PE scatter/multicast counterpart of the PE→GLB gather network.
- Accepts one data word plus a (tag_Y, tag_X) pair from the GLB-side controller per transfer.
- Delivers the word to every PE whose programmed row ID equals tag_Y and whose column ID equals tag_X.
- Single-entry buffered, with per-PE delivery tracking; sits between GLB read port and the PE array inputs.

Parameters:
NUMS_PE_ROW, 6, PE array rows (Y dimension)
NUMS_PE_COL, 8, PEs per row (X dimension)
DATA_BITS, 32, payload width
XID_BITS, 5, column ID/tag width
YID_BITS, 5, row ID/tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
GIN_valid  in  1  GLB word valid
GIN_ready  out  1  GIN can accept word
GIN_data  in  DATA_BITS  payload
tag_X  in  XID_BITS  target column tag, qualified by GIN_valid
tag_Y  in  YID_BITS  target row tag, qualified by GIN_valid
set_XID  in  1  shift XID scan chain
XID_scan_in  in  XID_BITS  XID chain input
set_YID  in  1  shift YID scan chain
YID_scan_in  in  YID_BITS  YID chain input
PE_valid  out  NUMS_PE_ROW*NUMS_PE_COL  per-PE valid; PE index = row*NUMS_PE_COL+col
PE_ready  in  NUMS_PE_ROW*NUMS_PE_COL  per-PE ready
PE_data  out  DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL  buffered payload, replicated to every PE slot

Behaviour:

ID chains:
- YID chain: NUMS_PE_ROW registers.
- XID chain: NUMS_PE_ROW*NUMS_PE_COL registers, running row 0 col 0 through last row, last col.
- On a rising clk with set_*=1: reg[0] <= scan_in and reg[k] <= reg[k-1]. Fully loading a chain takes N shifts; the first value shifted in ends at the last index.
- IDs hold while set_*=0.
- All IDs reset to 0.

Target mask:
- target[r*C+c] = (YID[r]==tag_Y) && (XID[r*C+c]==tag_X).
- The mask is computed from the current ID registers in the accept cycle.

Datapath state:
- data_q (DATA_BITS) and pending (R*C mask).
- busy = |pending.

Accept:
- Occurs when GIN_valid && GIN_ready.
- data_q <= GIN_data and pending <= target.
- PE_valid rises the next cycle (latency 1).

PE handshake:
- PE_valid = pending.
- Each cycle, pending <= pending & ~PE_ready.
- PEs complete independently, in any order, over any number of cycles.
- PE_valid never depends combinationally on PE_ready, and a valid never drops before its ready.

Ready and throughput:
- GIN_ready = (pending & ~PE_ready)==0, i.e. idle, or the last outstanding PEs complete this cycle.
- This gives 1 word/cycle throughput.
- An accept in the same cycle as the final completion overwrites pending with the new mask; no bubble.

Zero-target tag:
- The word is accepted, pending=0, and it is silently dropped.
- GIN_ready stays 1.

Data hold:
- PE_data holds data_q unchanged while busy.
- data_q changes only on accept.

Config during busy:
- set_XID/set_YID while busy does not alter pending or data_q.
- It affects only future accepts.

Reset:
- Reset mid-transfer clears pending, data_q and IDs to 0.
- PE_valid=0 and GIN_ready=1 at the first cycle after reset release.
- Reset values: PE_valid=0, PE_data=0, GIN_ready=1.

Decomposition:
- Shared package holds the defaults for NUMS_PE_ROW, NUMS_PE_COL, DATA_BITS, XID_BITS, YID_BITS and a PE-index helper (row*NUMS_PE_COL+col).
- One sub-module: gin_id_scan_chain (params DEPTH, ID_SIZE; ports clk, rst, set_id, ID_scan_in, ID_scan_out, flat ID vector out).
- The sub-module is instantiated twice: the YID chain with DEPTH=NUMS_PE_ROW, the XID chain with DEPTH=NUMS_PE_ROW*NUMS_PE_COL.
- Mask generation and pending/data registers live in gin.

Test Plan:
1. Load YID=row index and XID=col index via scan chains (48 XID shifts, 6 YID shifts); send tag_Y=2, tag_X=5, data=0xDEADBEEF with all PE_ready=1 → only PE_valid[21] high for exactly 1 cycle, one cycle after accept; PE_data slot 21=0xDEADBEEF.
2. Multicast: XID all 3, YID all 0; send tag(0,3), data=0x11; hold PE_ready=0 for 4 cycles, then release PEs 0..47 one per cycle → all 48 valids asserted, each drops the cycle after its ready; GIN_ready=0 until the last completes; a second word is accepted in that same final cycle.
3. Back-to-back throughput: 10 words, unicast targets, PE_ready=1 → GIN_ready stays 1 and the target PE receives each word on consecutive cycles, in order (0x1..0xA).
4. Zero-target: tag_Y=31 matching no row → word accepted, no PE_valid asserts, GIN_ready remains 1.
5. Reconfig while busy: word pending at PE 9 with PE_ready=0; shift new XIDs → PE_valid[9] persists and data is unchanged; after completion, a new tag uses the new IDs.
6. Reset mid-transfer: pending mask 0xFF, assert rst asynchronously between edges → PE_valid=0 immediately; after release, GIN_ready=1 and all IDs read 0 (a tag(0,0) word targets all 48 PEs).
